// File: rtl/vlc_pkg.sv
// vlc_pkg: shared mode encoding and sweep-phase constants for the lamp sequencer.
package vlc_pkg;
    typedef enum logic [1:0] {
        IDLE   = 2'b00,
        LEFT   = 2'b01,
        RIGHT  = 2'b10,
        HAZARD = 2'b11
    } mode_t;
    localparam int PHASE_W = 2;
    localparam logic [PHASE_W-1:0] PHASE_LAST = 2'd3;
endpackage

// File: rtl/vlc_debounce.sv
// vlc_debounce: 2-flop synchroniser followed by a consecutive-sample filter.
module vlc_debounce #(
    parameter int DEB_CYCLES = 4
) (
    input  logic clk,
    input  logic rst_n,
    input  logic d_i,
    output logic q_o
);
    localparam int CW = $clog2(DEB_CYCLES) + 1;
    logic [1:0]    sync_q;
    logic          filt_q, filt_d;
    logic [CW-1:0] cnt_q, cnt_d;
    always_comb begin
        filt_d = filt_q;
        cnt_d  = '0;
        if (sync_q[1] != filt_q) begin
            if (cnt_q == CW'(DEB_CYCLES - 1)) filt_d = ~filt_q;
            else cnt_d = cnt_q + 1'b1;
        end
    end
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_q <= '0;
            filt_q <= 1'b0;
            cnt_q  <= '0;
        end else begin
            sync_q <= {sync_q[0], d_i};
            filt_q <= filt_d;
            cnt_q  <= cnt_d;
        end
    end
    assign q_o = filt_q;
endmodule

// File: rtl/vlc_turn_sched.sv
// vlc_turn_sched: debounces the turn/hazard switches, arbitrates a lamp mode and
// generates the prescaled step tick and sweep phase for the lamp decoder.
module vlc_turn_sched
    import vlc_pkg::*;
#(
    parameter int TICK_DIV   = 2_500_000,
    parameter int DEB_CYCLES = 4
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               req_left,
    input  logic               req_right,
    input  logic               req_hazard,
    output logic [1:0]         mode_o,
    output logic [PHASE_W-1:0] phase_o,
    output logic               tick_o,
    output logic               busy_o
);
    localparam int CW = $clog2(TICK_DIV);
    logic               f_left, f_right, f_hazard, last;
    mode_t              want, mode_q, mode_d;
    logic [CW-1:0]      cnt_q, cnt_d;
    logic [PHASE_W-1:0] phase_q, phase_d;
    logic               tick_q, tick_d;

    vlc_debounce #(.DEB_CYCLES(DEB_CYCLES)) u_deb_left   (.clk(clk), .rst_n(rst_n), .d_i(req_left),   .q_o(f_left));
    vlc_debounce #(.DEB_CYCLES(DEB_CYCLES)) u_deb_right  (.clk(clk), .rst_n(rst_n), .d_i(req_right),  .q_o(f_right));
    vlc_debounce #(.DEB_CYCLES(DEB_CYCLES)) u_deb_hazard (.clk(clk), .rst_n(rst_n), .d_i(req_hazard), .q_o(f_hazard));

    // Non-hazard changes wait for the 3->0 wrap; hazard preempts immediately and restarts the sweep.
    always_comb begin
        want    = (f_hazard || (f_left && f_right)) ? HAZARD : f_left ? LEFT : f_right ? RIGHT : IDLE;
        last    = cnt_q == CW'(TICK_DIV - 1);
        mode_d  = mode_q;
        phase_d = '0;
        cnt_d   = '0;
        tick_d  = 1'b0;
        if (mode_q == IDLE) begin
            mode_d = want;
        end else if (want == HAZARD && mode_q != HAZARD) begin
            mode_d = HAZARD;
        end else if (last) begin
            tick_d  = 1'b1;
            phase_d = phase_q + 1'b1;
            mode_d  = (phase_q == PHASE_LAST) ? want : mode_q;
        end else begin
            cnt_d   = cnt_q + 1'b1;
            phase_d = phase_q;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mode_q  <= IDLE;
            cnt_q   <= '0;
            phase_q <= '0;
            tick_q  <= 1'b0;
        end else begin
            mode_q  <= mode_d;
            cnt_q   <= cnt_d;
            phase_q <= phase_d;
            tick_q  <= tick_d;
        end
    end

    assign mode_o  = mode_q;
    assign phase_o = phase_q;
    assign tick_o  = tick_q;
    assign busy_o  = mode_q != IDLE;
endmodule

// File: tb/tb_vlc_turn_sched.sv
// tb_vlc_turn_sched: directed scenarios plus random switch activity against a
// window-based debounce model and an elapsed-cycle sweep model.
module tb_vlc_turn_sched;
    localparam int TD  = 8;
    localparam int DEB = 4;

    logic       clk = 1'b0, rst_n = 1'b0;
    logic       rl = 1'b0, rr = 1'b0, rh = 1'b0;
    logic [1:0] mode_o, phase_o;
    logic       tick_o, busy_o;
    int         checks = 0, errors = 0;

    logic [2:0] hist[$];
    logic [2:0] filt;
    int         m_mode, k;
    bit         m_tick;

    always #5 clk = ~clk;

    vlc_turn_sched #(.TICK_DIV(TD), .DEB_CYCLES(DEB)) dut (
        .clk(clk), .rst_n(rst_n), .req_left(rl), .req_right(rr), .req_hazard(rh),
        .mode_o(mode_o), .phase_o(phase_o), .tick_o(tick_o), .busy_o(busy_o)
    );

    task automatic check(input string tag, input logic [3:0] obs, input logic [3:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        hist.delete();
        for (int i = 0; i < DEB + 2; i++) hist.push_back(3'b000);
        filt = 3'b000; m_mode = 0; k = 0; m_tick = 0;
    endtask

    function automatic int m_phase();
        return (m_mode == 0) ? 0 : (k / TD) % 4;
    endfunction

    // Filter flips once the DEB synchronised samples preceding the edge all disagree with it.
    task automatic model_edge();
        int want;
        logic [2:0] f;
        want = (filt[2] || (filt[0] && filt[1])) ? 3 : filt[0] ? 1 : filt[1] ? 2 : 0;
        hist.push_back({rh, rr, rl});
        f = filt;
        for (int b = 0; b < 3; b++) begin
            bit all_diff = 1;
            for (int j = 2; j <= DEB + 1; j++)
                if (hist[hist.size() - 1 - j][b] == filt[b]) all_diff = 0;
            if (all_diff) f[b] = ~filt[b];
        end
        filt = f;
        if (hist.size() > 32) void'(hist.pop_front());
        m_tick = 0;
        if (m_mode == 0) begin
            if (want != 0) begin m_mode = want; k = 0; end
        end else if (want == 3 && m_mode != 3) begin
            m_mode = 3; k = 0;
        end else begin
            k++;
            m_tick = (k % TD) == 0;
            if (m_tick && (k / TD) % 4 == 0) begin m_mode = want; k = 0; end
        end
    endtask

    task automatic cycle();
        @(posedge clk);
        model_edge();
        @(negedge clk);
        check("mode", 4'(mode_o), 4'(m_mode));
        check("phase", 4'(phase_o), 4'(m_phase()));
        check("tick", 4'(tick_o), 4'(m_tick));
        check("busy", 4'(busy_o), 4'(m_mode != 0));
    endtask

    task automatic async_reset(input string tag);
        #2 rst_n = 1'b0;
        #1;
        check({tag, "_mode"}, 4'(mode_o), 4'd0);
        check({tag, "_phase"}, 4'(phase_o), 4'd0);
        check({tag, "_tick"}, 4'(tick_o), 4'd0);
        check({tag, "_busy"}, 4'(busy_o), 4'd0);
        model_reset();
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    initial begin
        int n;
        model_reset();
        repeat (2) @(negedge clk);
        check("reset_mode", 4'(mode_o), 4'd0);
        check("reset_busy", 4'(busy_o), 4'd0);
        rst_n = 1'b1;

        // Left sweep: load at edge 7, ticks at 15/23/31/39 with phases 1,2,3,0
        rl = 1'b1;
        for (int i = 1; i <= 40; i++) begin
            cycle();
            if (i == 6) check("left_pre_load", 4'(mode_o), 4'd0);
            if (i == 7) check("left_load", 4'(mode_o), 4'd1);
            if (i == 15) check("left_tick15", 4'({tick_o, phase_o}), 4'b101);
            if (i == 23) check("left_tick23", 4'({tick_o, phase_o}), 4'b110);
            if (i == 31) check("left_tick31", 4'({tick_o, phase_o}), 4'b111);
            if (i == 39) check("left_tick39", 4'({tick_o, phase_o}), 4'b100);
        end

        // Deferred release and switch to right
        n = 0;
        while (n < 64 && phase_o != 2'd1) begin cycle(); n++; end
        check("wait_phase1", 4'(phase_o), 4'd1);
        rl = 1'b0; rr = 1'b1;
        n = 0;
        while (n < 64 && mode_o == 2'd1) begin cycle(); n++; end
        check("switch_mode", 4'(mode_o), 4'd2);
        check("switch_tick", 4'(tick_o), 4'd1);
        check("switch_phase", 4'(phase_o), 4'd0);

        // Hazard preempt at phase 2
        n = 0;
        while (n < 64 && phase_o != 2'd2) begin cycle(); n++; end
        check("wait_phase2", 4'(phase_o), 4'd2);
        rh = 1'b1;
        n = 0;
        while (n < 20 && mode_o != 2'd3) begin cycle(); n++; end
        check("preempt_mode", 4'(mode_o), 4'd3);
        check("preempt_phase", 4'(phase_o), 4'd0);
        for (int i = 1; i <= TD; i++) begin
            cycle();
            if (i < TD) check("preempt_no_early_tick", 4'(tick_o), 4'd0);
        end
        check("preempt_first_tick", 4'(tick_o), 4'd1);
        rh = 1'b0;
        n = 0;
        while (n < 80 && mode_o != 2'd2) begin cycle(); n++; end
        check("hazard_back_right", 4'(mode_o), 4'd2);

        // Preempt landing on a tick edge: raw rise sampled 7 edges before the load
        n = 0;
        while (n < 64 && !(m_mode == 2 && k % TD == 1)) begin cycle(); n++; end
        check("wait_tick_align", 4'(k % TD), 4'd1);
        rh = 1'b1;
        repeat (7) cycle();
        check("preempt_tick_mode", 4'(mode_o), 4'd3);
        check("preempt_tick_suppressed", 4'(tick_o), 4'd0);
        check("preempt_tick_phase", 4'(phase_o), 4'd0);

        // Release everything back to idle
        rh = 1'b0; rr = 1'b0;
        n = 0;
        while (n < 80 && mode_o != 2'd0) begin cycle(); n++; end
        check("release_idle", 4'(mode_o), 4'd0);

        // Glitch rejection: 3-cycle pulse
        rr = 1'b1;
        repeat (3) cycle();
        rr = 1'b0;
        repeat (12) cycle();
        check("glitch_mode", 4'(mode_o), 4'd0);
        check("glitch_busy", 4'(busy_o), 4'd0);

        // Simultaneous left+right gives hazard; dropping right returns to left at wrap
        rl = 1'b1; rr = 1'b1;
        repeat (7) cycle();
        check("both_hazard", 4'(mode_o), 4'd3);
        rr = 1'b0;
        repeat (10) cycle();
        check("both_hold_hazard", 4'(mode_o), 4'd3);
        n = 0;
        while (n < 64 && mode_o != 2'd1) begin cycle(); n++; end
        check("both_to_left", 4'(mode_o), 4'd1);
        check("both_to_left_phase", 4'(phase_o), 4'd0);

        // Reset mid-sweep at phase 3, request still held
        n = 0;
        while (n < 64 && phase_o != 2'd3) begin cycle(); n++; end
        check("wait_phase3", 4'(phase_o), 4'd3);
        async_reset("midrst");
        for (int i = 1; i <= 7; i++) begin
            cycle();
            if (i == 6) check("rst_reload_pre", 4'(mode_o), 4'd0);
        end
        check("rst_reload", 4'(mode_o), 4'd1);

        // Random switch activity with occasional asynchronous resets
        for (int s = 0; s < 150; s++) begin
            {rh, rr, rl} = 3'($urandom_range(0, 7));
            if ($urandom_range(0, 3) == 0) rh = 1'b0;
            repeat ($urandom_range(1, 40)) cycle();
            if ($urandom_range(0, 30) == 0) async_reset("rand_rst");
        end

        rl = 1'b0; rr = 1'b0; rh = 1'b0;
        repeat (60) cycle();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
